// File: rtl/drfm_sdram_master.sv
// DRFM SDRAM master: captures an ADC sample record into SDRAM over Avalon-MM
// and replays it once or in a loop toward the DAC path.
module drfm_sdram_master #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_length,
    input  logic              cmd_capture,
    input  logic              cmd_replay,
    input  logic              cmd_loop,
    input  logic              cmd_stop,
    output logic [1:0]        state,
    output logic              busy,
    output logic              overflow,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [1:0]        m_byteenable_n,
    output logic              m_chipselect,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read_n,
    output logic              m_write_n,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPLAY  = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t st;

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic              loop_r;

    logic [DATA_W-1:0] w_mem [FIFO_DEPTH];
    logic [PW-1:0]     w_rd;
    logic [PW-1:0]     w_wr;
    logic [CW-1:0]     w_count;
    logic [ADDR_W-1:0] push_cnt;
    logic [ADDR_W-1:0] wr_acc_cnt;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     outst;
    logic [ADDR_W-1:0] roff;
    logic              rd_done;

    logic              w_acc;
    logic              r_acc;
    logic              w_hold;
    logic              r_hold;
    logic              stop_now;
    logic              cap_take;
    logic              w_push;
    logic              w_drop;
    logic [PW-1:0]     w_rd_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic [ADDR_W-1:0] wcnt_nxt;
    logic              cap_done;
    logic              r_push;
    logic              r_pop;
    logic              r_ret;
    logic [CW-1:0]     r_count_nxt;
    logic [CW-1:0]     outst_nxt;
    logic              r_wrap;
    logic [ADDR_W-1:0] roff_nxt;
    logic              rd_done_nxt;
    logic              credit_ok;
    logic              r_issue;
    logic              rep_done;

    assign state          = st;
    assign busy           = (st != ST_IDLE);
    assign m_byteenable_n = 2'b00;
    assign out_data       = r_mem[r_rd];

    // Next-state terms for both FIFOs, the request slot and the counters
    always_comb begin
        w_acc       = ~m_write_n & ~m_waitrequest;
        r_acc       = ~m_read_n & ~m_waitrequest;
        w_hold      = ~m_write_n & m_waitrequest;
        r_hold      = ~m_read_n & m_waitrequest;
        stop_now    = cmd_stop & ((st == ST_CAPTURE) | (st == ST_REPLAY));

        cap_take    = (st == ST_CAPTURE) & ~cmd_stop & in_valid
                      & (push_cnt != len_r);
        w_push      = cap_take & (w_count != FULL);
        w_drop      = cap_take & (w_count == FULL);
        w_rd_nxt    = w_rd + PW'(w_acc);
        w_count_nxt = w_count + CW'(w_push) - CW'(w_acc);
        w_head_nxt  = w_mem[w_rd_nxt];
        if ((w_count - CW'(w_acc)) == '0) begin
            w_head_nxt = in_data;
        end
        wcnt_nxt    = wr_acc_cnt + ADDR_W'(w_acc);
        cap_done    = w_acc & (wr_acc_cnt == (len_r - ADDR_W'(1)));

        r_push      = (st == ST_REPLAY) & ~cmd_stop & m_readdatavalid;
        r_pop       = out_valid & out_ready;
        r_ret       = m_readdatavalid & (outst != '0);
        r_count_nxt = r_count + CW'(r_push) - CW'(r_pop);
        outst_nxt   = outst + CW'(r_acc) - CW'(r_ret);
        r_wrap      = r_acc & (roff == (len_r - ADDR_W'(1)));
        roff_nxt    = roff;
        if (r_acc) begin
            roff_nxt = r_wrap ? '0 : roff + ADDR_W'(1);
        end
        rd_done_nxt = rd_done | (r_wrap & ~loop_r);
        credit_ok   = ({1'b0, outst_nxt} + {1'b0, r_count_nxt})
                      < {1'b0, FULL};
        r_issue     = (st == ST_REPLAY) & ~cmd_stop & ~rd_done_nxt
                      & credit_ok;
        rep_done    = rd_done_nxt & (outst_nxt == '0)
                      & (r_count_nxt == '0) & ~r_hold;
    end

    // FIFO storage; pointers and counts live in the control block
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            w_mem[w_wr] <= in_data;
        end
        if (r_push) begin
            r_mem[r_wr] <= m_readdata;
        end
    end

    // Control FSM with registered Avalon request, stream and status outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            st           <= ST_IDLE;
            base_r       <= '0;
            len_r        <= '0;
            loop_r       <= 1'b0;
            overflow     <= 1'b0;
            w_rd         <= '0;
            w_wr         <= '0;
            w_count      <= '0;
            push_cnt     <= '0;
            wr_acc_cnt   <= '0;
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            outst        <= '0;
            roff         <= '0;
            rd_done      <= 1'b0;
            out_valid    <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_read_n     <= 1'b1;
            m_write_n    <= 1'b1;
            m_chipselect <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    m_read_n     <= 1'b1;
                    m_write_n    <= 1'b1;
                    m_chipselect <= 1'b0;
                    out_valid    <= 1'b0;
                    if (cmd_capture && cfg_length != '0) begin
                        st         <= ST_CAPTURE;
                        base_r     <= cfg_base_addr;
                        len_r      <= cfg_length;
                        overflow   <= 1'b0;
                        push_cnt   <= '0;
                        wr_acc_cnt <= '0;
                        w_rd       <= '0;
                        w_wr       <= '0;
                        w_count    <= '0;
                        m_address  <= cfg_base_addr;
                    end else if (cmd_replay && cfg_length != '0) begin
                        st        <= ST_REPLAY;
                        base_r    <= cfg_base_addr;
                        len_r     <= cfg_length;
                        loop_r    <= cmd_loop;
                        roff      <= '0;
                        rd_done   <= 1'b0;
                        outst     <= '0;
                        r_rd      <= '0;
                        r_wr      <= '0;
                        r_count   <= '0;
                        m_address <= cfg_base_addr;
                    end
                end
                ST_CAPTURE: begin
                    if (stop_now) begin
                        st           <= ST_DRAIN;
                        w_rd         <= '0;
                        w_wr         <= '0;
                        w_count      <= '0;
                        m_write_n    <= ~w_hold;
                        m_chipselect <= w_hold;
                    end else begin
                        w_rd        <= w_rd_nxt;
                        w_wr        <= w_wr + PW'(w_push);
                        w_count     <= w_count_nxt;
                        push_cnt    <= push_cnt + ADDR_W'(w_push);
                        wr_acc_cnt  <= wcnt_nxt;
                        m_address   <= base_r + wcnt_nxt;
                        m_writedata <= w_head_nxt;
                        if (w_drop) begin
                            overflow <= 1'b1;
                        end
                        if (cap_done) begin
                            st           <= ST_IDLE;
                            m_write_n    <= 1'b1;
                            m_chipselect <= 1'b0;
                        end else begin
                            m_write_n    <= (w_count_nxt == '0);
                            m_chipselect <= (w_count_nxt != '0);
                        end
                    end
                end
                ST_REPLAY: begin
                    outst <= outst_nxt;
                    if (stop_now) begin
                        st           <= ST_DRAIN;
                        r_rd         <= '0;
                        r_wr         <= '0;
                        r_count      <= '0;
                        out_valid    <= 1'b0;
                        m_read_n     <= ~r_hold;
                        m_chipselect <= r_hold;
                    end else begin
                        roff      <= roff_nxt;
                        rd_done   <= rd_done_nxt;
                        r_rd      <= r_rd + PW'(r_pop);
                        r_wr      <= r_wr + PW'(r_push);
                        r_count   <= r_count_nxt;
                        out_valid <= (r_count_nxt != '0);
                        if (r_hold) begin
                            m_read_n     <= 1'b0;
                            m_chipselect <= 1'b1;
                        end else if (r_issue) begin
                            m_read_n     <= 1'b0;
                            m_chipselect <= 1'b1;
                            m_address    <= base_r + roff_nxt;
                        end else begin
                            m_read_n     <= 1'b1;
                            m_chipselect <= 1'b0;
                        end
                        if (rep_done) begin
                            st <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    outst        <= outst_nxt;
                    out_valid    <= 1'b0;
                    m_read_n     <= ~r_hold;
                    m_write_n    <= ~w_hold;
                    m_chipselect <= r_hold | w_hold;
                    if (outst_nxt == '0 && !r_hold && !w_hold) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drfm_sdram_master.sv
// Bench for drfm_sdram_master: SDRAM slave model with random latency and
// waitrequest, record-level expectations for capture and replay.
module tb_drfm_sdram_master;

    logic        clk_clk;
    logic        reset_reset;
    logic [24:0] cfg_base_addr;
    logic [24:0] cfg_length;
    logic        cmd_capture;
    logic        cmd_replay;
    logic        cmd_loop;
    logic        cmd_stop;
    logic [1:0]  state;
    logic        busy;
    logic        overflow;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] m_address;
    logic [1:0]  m_byteenable_n;
    logic        m_chipselect;
    logic [15:0] m_writedata;
    logic        m_read_n;
    logic        m_write_n;
    logic [15:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_waitrequest;

    drfm_sdram_master dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_length      (cfg_length),
        .cmd_capture     (cmd_capture),
        .cmd_replay      (cmd_replay),
        .cmd_loop        (cmd_loop),
        .cmd_stop        (cmd_stop),
        .state           (state),
        .busy            (busy),
        .overflow        (overflow),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .m_address       (m_address),
        .m_byteenable_n  (m_byteenable_n),
        .m_chipselect    (m_chipselect),
        .m_writedata     (m_writedata),
        .m_read_n        (m_read_n),
        .m_write_n       (m_write_n),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [15:0] sdram [int];
    int          wr_addr [$];
    logic [15:0] wr_data [$];
    int          rd_addr [$];
    logic [15:0] outs [$];
    int          rq_addr [$];
    int          rq_due [$];
    int          samp_cyc [$];
    int          wacc_cyc [$];
    logic [15:0] smp [40];

    int out_cnt = 0;
    int max_out = 0;
    int wait_mode = 0;
    int ready_mode = 1;
    int lat_min = 3;
    int lat_max = 3;
    int last_due = 0;
    int both_low = 0;
    int hold_viol = 0;
    int drain_reads = 0;
    int drain_outs = 0;

    logic        prev_hold = 1'b0;
    logic        prev_rn = 1'b1;
    logic        prev_wn = 1'b1;
    logic [24:0] prev_addr = '0;
    logic [15:0] prev_wd = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sd_rd(input int a);
        if (sdram.exists(a)) return sdram[a];
        return 16'(a ^ 32'h5A5A);
    endfunction

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        outs.delete();
        samp_cyc.delete();
        wacc_cyc.delete();
        max_out = 0;
        drain_reads = 0;
        drain_outs = 0;
    endtask

    // One clock: observe bus at negedge, then drive slave and sink inputs
    task automatic cycle();
        int due;
        logic held_before;
        @(negedge clk_clk);
        held_before = prev_hold;
        if (!m_read_n && !m_write_n) both_low++;
        if (prev_hold) begin
            if (prev_rn != m_read_n || prev_wn != m_write_n ||
                prev_addr != m_address ||
                (!prev_wn && prev_wd != m_writedata)) hold_viol++;
        end
        prev_hold = (!m_read_n || !m_write_n) && m_waitrequest && !reset_reset;
        prev_rn = m_read_n;
        prev_wn = m_write_n;
        prev_addr = m_address;
        prev_wd = m_writedata;
        if (!reset_reset) begin
            if (in_valid && state == 2'd1) samp_cyc.push_back(cyc);
            if (!m_write_n && !m_waitrequest) begin
                wr_addr.push_back(int'(m_address));
                wr_data.push_back(m_writedata);
                sdram[int'(m_address)] = m_writedata;
                wacc_cyc.push_back(cyc);
            end
            if (!m_read_n && !m_waitrequest) begin
                rd_addr.push_back(int'(m_address));
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq_addr.push_back(int'(m_address));
                rq_due.push_back(due);
                out_cnt++;
                if (out_cnt > max_out) max_out = out_cnt;
                if (state == 2'd3 && !held_before) drain_reads++;
            end
            if (out_valid && out_ready) begin
                outs.push_back(out_data);
                if (state == 2'd3) drain_outs++;
            end
        end
        @(posedge clk_clk);
        cyc++;
        #1;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            m_readdatavalid = 1'b1;
            m_readdata = sd_rd(rq_addr.pop_front());
            void'(rq_due.pop_front());
            out_cnt--;
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata = 16'($urandom);
        end
        case (wait_mode)
            0: m_waitrequest = 1'b0;
            1: m_waitrequest = 1'b1;
            default: m_waitrequest = ($urandom_range(3, 0) == 0);
        endcase
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n;
        n = 0;
        while (state != 2'd0 && n < maxc) begin
            cycle();
            n++;
        end
        chk(tag, 32'(state), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] ea;
        reset_reset = 1'b1;
        cfg_base_addr = '0;
        cfg_length = '0;
        cmd_capture = 1'b0;
        cmd_replay = 1'b0;
        cmd_loop = 1'b0;
        cmd_stop = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        m_readdata = '0;
        m_readdatavalid = 1'b0;
        m_waitrequest = 1'b0;
        repeat (3) cycle();

        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_read_n", 32'(m_read_n), 1);
        chk("rst_write_n", 32'(m_write_n), 1);
        chk("rst_cs", 32'(m_chipselect), 0);
        chk("rst_addr", 32'(m_address), 0);
        chk("rst_wdata", 32'(m_writedata), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_be_n", 32'(m_byteenable_n), 0);
        reset_reset = 1'b0;
        cycle();

        // zero length and idle stop are ignored
        cfg_base_addr = 25'h100;
        cfg_length = '0;
        cmd_capture = 1'b1;
        cycle();
        cmd_capture = 1'b0;
        chk("len0_capture", 32'(state), 0);
        cmd_replay = 1'b1;
        cycle();
        cmd_replay = 1'b0;
        chk("len0_replay", 32'(state), 0);
        cmd_stop = 1'b1;
        cycle();
        cmd_stop = 1'b0;
        chk("stop_in_idle", 32'(state), 0);

        // capture ramp; samples past the length are ignored
        clear_logs();
        cfg_length = 25'd8;
        cmd_capture = 1'b1;
        cycle();
        cmd_capture = 1'b0;
        chk("cap_state", 32'(state), 1);
        chk("cap_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 16'(i);
            cycle();
        end
        in_valid = 1'b0;
        wait_idle(60, "cap_idle");
        chk("cap_nwr", 32'(wr_addr.size()), 8);
        for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
            chk($sformatf("cap_addr%0d", i), 32'(wr_addr[i]), 32'h100 + 32'(i));
            chk($sformatf("cap_data%0d", i), 32'(wr_data[i]), 32'(i));
        end
        if (wacc_cyc.size() > 0 && samp_cyc.size() > 0)
            chk("cap_first_wr_lat", 32'(wacc_cyc[0] - samp_cyc[0]), 1);
        repeat (5) cycle();
        chk("cap_no_extra_wr", 32'(wr_addr.size()), 8);

        // capture against a stalled slave: FIFO fills, rest dropped
        clear_logs();
        cfg_base_addr = 25'h2000;
        cfg_length = 25'd32;
        wait_mode = 1;
        m_waitrequest = 1'b1;
        cmd_capture = 1'b1;
        cycle();
        cmd_capture = 1'b0;
        for (int i = 0; i < 40; i++) begin
            smp[i] = 16'($urandom);
            in_valid = (i < 32);
            in_data = smp[i];
            cmd_replay = (i == 20);
            cycle();
        end
        in_valid = 1'b0;
        cmd_replay = 1'b0;
        chk("ovf_replay_ignored", 32'(state), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_no_wr_stalled", 32'(wr_addr.size()), 0);
        wait_mode = 0;
        m_waitrequest = 1'b0;
        repeat (40) cycle();
        chk("ovf_nwr", 32'(wr_addr.size()), 16);
        for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
            chk($sformatf("ovf_data%0d", i), 32'(wr_data[i]), 32'(smp[i]));
            chk($sformatf("ovf_addr%0d", i), 32'(wr_addr[i]), 32'h2000 + 32'(i));
        end
        chk("ovf_still_capture", 32'(state), 1);
        cmd_stop = 1'b1;
        cycle();
        cmd_stop = 1'b0;
        chk("ovf_drain", 32'(state), 3);
        wait_idle(20, "ovf_idle");

        // single replay of the ramp
        clear_logs();
        cfg_base_addr = 25'h100;
        cfg_length = 25'd8;
        cmd_loop = 1'b0;
        lat_min = 3;
        lat_max = 3;
        cmd_replay = 1'b1;
        cycle();
        cmd_replay = 1'b0;
        chk("rep_state", 32'(state), 2);
        wait_idle(100, "rep_idle");
        chk("rep_nout", 32'(outs.size()), 8);
        chk("rep_nrd", 32'(rd_addr.size()), 8);
        for (int i = 0; i < outs.size() && i < 8; i++)
            chk($sformatf("rep_out%0d", i), 32'(outs[i]), 32'(i));
        for (int i = 0; i < rd_addr.size() && i < 8; i++)
            chk($sformatf("rep_addr%0d", i), 32'(rd_addr[i]), 32'h100 + 32'(i));
        chk("rep_out_valid_low", 32'(out_valid), 0);

        // looped replay under random stalls, latency and backpressure
        clear_logs();
        cfg_length = 25'd4;
        cmd_loop = 1'b1;
        wait_mode = 2;
        ready_mode = 2;
        lat_min = 1;
        lat_max = 6;
        cmd_replay = 1'b1;
        cycle();
        cmd_replay = 1'b0;
        cmd_loop = 1'b0;
        repeat (300) cycle();
        chk("loop_still_replay", 32'(state), 2);
        cmd_stop = 1'b1;
        cycle();
        cmd_stop = 1'b0;
        wait_mode = 0;
        ready_mode = 1;
        chk("loop_stop_drain", 32'(state), 3);
        chk("loop_stop_out_valid", 32'(out_valid), 0);
        wait_idle(100, "loop_idle");
        chk("loop_progress", 32'(outs.size() >= 20), 1);
        for (int i = 0; i < outs.size(); i++)
            chk($sformatf("loop_out%0d", i), 32'(outs[i]), 32'(i % 4));
        for (int i = 0; i < rd_addr.size(); i++)
            chk($sformatf("loop_addr%0d", i), 32'(rd_addr[i]), 32'h100 + 32'(i % 4));
        chk("loop_max_outstanding", 32'(max_out <= 16), 1);
        chk("loop_drain_outs", 32'(drain_outs), 0);
        chk("loop_drain_reads", 32'(drain_reads), 0);
        chk("loop_idle_outstanding", 32'(out_cnt), 0);

        // stop with five reads in flight
        clear_logs();
        cfg_length = 25'd64;
        lat_min = 20;
        lat_max = 20;
        cmd_replay = 1'b1;
        cycle();
        cmd_replay = 1'b0;
        n = 0;
        while (out_cnt < 5 && n < 50) begin
            cycle();
            n++;
        end
        chk("stop5_reached", 32'(out_cnt), 5);
        cmd_stop = 1'b1;
        cycle();
        cmd_stop = 1'b0;
        chk("stop5_drain", 32'(state), 3);
        chk("stop5_out_valid", 32'(out_valid), 0);
        cycle();
        chk("stop5_still_drain", 32'(state), 3);
        wait_idle(100, "stop5_idle");
        chk("stop5_outstanding", 32'(out_cnt), 0);
        chk("stop5_nrd", 32'(rd_addr.size()), 6);
        chk("stop5_outs_dropped", 32'(outs.size()), 0);
        chk("stop5_drain_reads", 32'(drain_reads), 0);
        chk("stop5_out_valid_idle", 32'(out_valid), 0);

        // address wrap; capture wins over replay, overflow cleared
        clear_logs();
        chk("ovf_sticky", 32'(overflow), 1);
        cfg_base_addr = 25'h1FFFFFE;
        cfg_length = 25'd4;
        cmd_capture = 1'b1;
        cmd_replay = 1'b1;
        cycle();
        cmd_capture = 1'b0;
        cmd_replay = 1'b0;
        chk("wrap_capture_wins", 32'(state), 1);
        chk("wrap_ovf_cleared", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            smp[i] = 16'($urandom);
            in_valid = 1'b1;
            in_data = smp[i];
            cycle();
        end
        in_valid = 1'b0;
        wait_idle(40, "wrap_idle");
        chk("wrap_nwr", 32'(wr_addr.size()), 4);
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            ea = (32'h1FFFFFE + 32'(i)) & 32'h1FFFFFF;
            chk($sformatf("wrap_addr%0d", i), 32'(wr_addr[i]), ea);
            chk($sformatf("wrap_data%0d", i), 32'(wr_data[i]), 32'(smp[i]));
        end

        chk("bus_both_strobes_low", 32'(both_low), 0);
        chk("bus_hold_stable", 32'(hold_viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
